// File: rtl/counter.sv
// Free-running Size-bit up counter with synchronous, active-high reset.
// The count wraps silently from all-ones to zero.
module counter #(
    parameter int Size = 5
) (
    input  logic            clock,
    input  logic            reset,
    output logic [Size-1:0] count
);

    logic [Size-1:0] count_q;
    logic [Size-1:0] count_d;

    // Size-bit add: the carry out of the MSB is dropped, which gives the wrap.
    always_comb begin
        count_d = count_q + {{(Size-1){1'b0}}, 1'b1};
    end

    // Reset wins over increment on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: the driver pushes expected values into a queue,
// and a monitor pops and compares one entry 1 time unit after each rising edge.
module tb_counter;

    localparam int SIZE = 5;
    localparam int MOD  = 1 << SIZE;

    logic            clock;
    logic            reset;
    logic [SIZE-1:0] count;

    logic [SIZE-1:0] exp_q[$];
    string           tag_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: an integer count that is unknown until the first reset edge.
    bit model_known = 1'b0;
    int model_val   = 0;

    counter #(.Size(SIZE)) dut (
        .clock(clock),
        .reset(reset),
        .count(count)
    );

    // Clock and reset defaults
    initial begin
        clock = 1'b0;
        reset = 1'b0;
    end
    always #5 clock = ~clock;

    // Driver: set reset for the next edge and record what that edge must produce.
    task automatic step(input logic r, input string tag);
        @(negedge clock);
        reset = r;
        if (r) begin
            model_val   = 0;
            model_known = 1'b1;
        end else if (model_known) begin
            model_val = (model_val + 1) % MOD;
        end
        if (model_known) begin
            exp_q.push_back(model_val[SIZE-1:0]);
            tag_q.push_back(tag);
        end
    endtask

    // Reset pulses high between edges but is low when the next edge arrives.
    task automatic glitch_step(input string tag);
        @(negedge clock);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        if (model_known) begin
            model_val = (model_val + 1) % MOD;
            exp_q.push_back(model_val[SIZE-1:0]);
            tag_q.push_back(tag);
        end
    endtask

    task automatic run(input logic r, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step(r, tag);
        end
    endtask

    // Monitor / scoreboard
    always @(posedge clock) begin
        logic [SIZE-1:0] exp_v;
        string           tag_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag_v = tag_q.pop_front();
            total_cnt++;
            if (count === exp_v) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: count=%0d expected=%0d at t=%0t", tag_v, count, exp_v, $time);
            end
        end
    end

    // Stimulus sequence
    initial begin
        // Pre-reset edges: the model is unknown, so nothing is queued.
        run(1'b0, 2, "pre_reset");

        run(1'b1, 3, "reset_hold");
        run(1'b0, 10, "count_1_to_10");

        run(1'b1, 1, "reset_before_wrap");
        run(1'b0, 31, "count_to_31");
        run(1'b0, 2, "wrap_0_then_1");

        run(1'b1, 1, "reset_before_17");
        run(1'b0, 17, "count_to_17");
        run(1'b1, 1, "reset_at_17");
        run(1'b0, 2, "after_reset_17");

        run(1'b1, 1, "reset_before_31");
        run(1'b0, 31, "count_to_31b");
        run(1'b1, 1, "reset_at_31");
        run(1'b0, 1, "after_reset_31");

        run(1'b1, 1, "reset_before_glitch");
        run(1'b0, 5, "count_to_5");
        glitch_step("glitch_ignored");
        run(1'b0, 1, "after_glitch");

        // Randomized reset pattern, roughly one reset in sixteen edges.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, "random");
        end

        // Let the monitor drain; a leftover entry means a missed check.
        @(posedge clock);
        #2;
        total_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Time bound on the whole run
    initial begin
        #200000;
        $display("FAIL timeout: run did not end, checked=%0d", total_cnt);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $finish;
    end

endmodule
